// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: packet-level round-robin arbiter for the shared FIFO read side.
// Define ARB_TIMEOUT_EN to abort a packet after TIMEOUT consecutive empty cycles.
module fifo_read_arbiter #(
    parameter int NPORTS  = 3,
    parameter int LEN_SZ  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS*LEN_SZ-1:0] req_len,
    input  logic                     rempty,
    output logic                     rinc,
    output logic [NPORTS-1:0]        gnt,
    output logic                     busy,
    output logic [NPORTS-1:0]        done,
    output logic [LEN_SZ-1:0]        beat_cnt,
    output logic                     err
);
    localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q;
    logic [NPORTS-1:0] gnt_q, gnt_d;
    logic [LEN_SZ-1:0] cnt_q, win_len;
    logic [PW-1:0]     last_q, win;
    logic              found, last_beat, timeout;

    // Scan from the farthest candidate inward so the nearest one after last_q wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        win   = last_q;
        found = 1'b0;
        for (int i = NPORTS; i >= 1; i--) begin
            idx = PW'((int'(last_q) + i) % NPORTS);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign win_len   = req_len[win*LEN_SZ +: LEN_SZ];
    assign gnt_d     = NPORTS'(1) << win;
    assign rinc      = (state_q == XFER) && !rempty;
    assign last_beat = rinc && (cnt_q == LEN_SZ'(1));
    assign done      = last_beat ? gnt_q :
                       ((state_q == IDLE) && found && (win_len == '0)) ? gnt_d : '0;
    assign gnt       = gnt_q;
    assign busy      = (state_q == XFER);
    assign beat_cnt  = cnt_q;

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
    assign timeout = (state_q == XFER) && rempty && (stall_q == SW'(TIMEOUT - 1));
    assign stall_d = ((state_q == XFER) && rempty && !timeout) ? stall_q + 1'b1 : '0;
    assign err     = timeout;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= PW'(NPORTS - 1);
        end else if (state_q == IDLE) begin
            if (found) begin
                last_q <= win;
                if (win_len != '0) begin
                    state_q <= XFER;
                    gnt_q   <= gnt_d;
                    cnt_q   <= win_len;
                end
            end
        end else if (last_beat || timeout) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else if (rinc) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed and random stimulus against a packet-level reference model.
module tb_fifo_read_arbiter;
    localparam int N  = 3;
    localparam int L  = 8;
    localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*L-1:0] req_len = '0;
    logic          rempty = 1'b0;
    logic          rinc, busy, err;
    logic [N-1:0]  gnt, done;
    logic [L-1:0]  beat_cnt;

    fifo_read_arbiter #(.NPORTS(N), .LEN_SZ(L), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .rempty(rempty),
        .rinc(rinc), .gnt(gnt), .busy(busy), .done(done), .beat_cnt(beat_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit m_pkt;
    int m_port, m_left, m_last, m_stall;
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] order[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*L-1:0] pk(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_pkt = 0; m_port = 0; m_left = 0; m_last = N - 1; m_stall = 0;
        prev_gnt = '0;
    endtask

    // Called just after a rising edge: pulls reset low and checks outputs clear at once.
    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(beat_cnt), 0);
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*L-1:0] l, input logic e);
        int w, wl;
        bit er;
        logic [31:0] eg, ed;
        req = r; req_len = l; rempty = e;
        @(negedge clk);
        w  = pick(r);
        wl = (w >= 0) ? int'(l[w*L +: L]) : -1;
        er = m_pkt && !e;
        eg = m_pkt ? (32'd1 << m_port) : 32'd0;
        if (er && m_left == 1) ed = eg;
        else if (!m_pkt && wl == 0) ed = 32'd1 << w;
        else ed = 32'd0;
        chk("gnt", 32'(gnt), eg);
        chk("busy", 32'(busy), 32'(m_pkt));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_left));
        chk("rinc", 32'(rinc), 32'(er));
        chk("done", 32'(done), ed);
        chk("err", 32'(err), 32'(TO_EN && m_pkt && e && m_stall == TO - 1));
        if (gnt != '0 && prev_gnt == '0) order.push_back(gnt);
        prev_gnt = gnt;
        @(posedge clk);
        #1;
        if (m_pkt) begin
            if (er) begin
                m_stall = 0;
                m_left--;
                if (m_left == 0) m_pkt = 0;
            end else begin
                m_stall++;
                if (TO_EN && m_stall == TO) begin m_pkt = 0; m_left = 0; m_stall = 0; end
            end
        end else if (w >= 0) begin
            m_last = w;
            if (wl > 0) begin m_pkt = 1; m_port = w; m_left = wl; m_stall = 0; end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        // single request on port 1
        step(3'b010, pk(0, 4, 0), 1'b0);
        repeat (5) step(3'b000, pk(0, 4, 0), 1'b0);
        // round robin from a fresh reset
        do_reset();
        order.delete();
        repeat (12) step(3'b111, pk(2, 2, 2), 1'b0);
        chk("rr_count", 32'(order.size() >= 4), 1);
        if (order.size() >= 4) begin
            chk("rr0", 32'(order[0]), 1);
            chk("rr1", 32'(order[1]), 2);
            chk("rr2", 32'(order[2]), 4);
            chk("rr3", 32'(order[3]), 1);
        end
        do_reset();
        // empty stall on port 2
        step(3'b100, pk(0, 0, 3), 1'b0);
        step(3'b000, pk(0, 0, 3), 1'b0);
        repeat (5) step(3'b000, pk(0, 0, 3), 1'b1);
        repeat (3) step(3'b000, pk(0, 0, 3), 1'b0);
        // zero length on port 0, then port 1 drops req mid-packet
        step(3'b011, pk(0, 3, 0), 1'b0);
        step(3'b010, pk(0, 3, 0), 1'b0);
        chk("zl_gnt1", 32'(gnt), 2);
        repeat (4) step(3'b000, pk(0, 3, 0), 1'b0);
        // reset mid-packet, then port 0 must win
        step(3'b010, pk(5, 5, 0), 1'b0);
        step(3'b000, pk(5, 5, 0), 1'b0);
        step(3'b000, pk(5, 5, 0), 1'b0);
        do_reset();
        step(3'b111, pk(1, 1, 1), 1'b0);
        chk("rst_prio", 32'(gnt), 1);
        repeat (2) step(3'b000, pk(1, 1, 1), 1'b0);
        // long stall: aborts with err only when the timeout is built in
        step(3'b100, pk(0, 0, 3), 1'b0);
        repeat (18) step(3'b000, pk(0, 0, 3), 1'b1);
        repeat (4) step(3'b000, pk(0, 0, 3), 1'b0);
        // random traffic
        repeat (1500)
            step(N'($urandom), pk($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5)),
                 $urandom_range(0, 3) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Packet-level round-robin arbiter that shares the router's single FIFO read side between `NPORTS` output ports. It sits between the output-port queues, which request whole packets, and `fifo_read_logic`, which it drives through `rinc` while watching `rempty`. A grant holds for exactly one packet, `req_len` beats, so a packet is never interleaved with another port's data.

## Interface
- `NPORTS`, 3: number of requesting output ports.
- `LEN_SZ`, 8: width of the per-request beat count.
- `TIMEOUT`, 16: stall-cycle limit. Used only when `ARB_TIMEOUT_EN` is defined.

- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  `NPORTS`: bit i high means port i has a packet pending.
- `req_len`  in  `NPORTS*LEN_SZ`: beat count for port i, in bits `[i*LEN_SZ +: LEN_SZ]`. Must be valid while `req[i]` is high.
- `rempty`  in  1: empty flag from `fifo_read_logic`.
- `rinc`  out  1: read increment to `fifo_read_logic`.
- `gnt`  out  `NPORTS`: one-hot grant, registered.
- `busy`  out  1: high while in XFER.
- `done`  out  `NPORTS`: one-cycle pulse on the granted port's last beat.
- `beat_cnt`  out  `LEN_SZ`: beats remaining in the current packet.
- `err`  out  1: one-cycle timeout-abort pulse.

## Operation
- **States:** IDLE and XFER.
- **Reset values:** `gnt`=0, `busy`=0, `beat_cnt`=0, `rinc`=0, `done`=0, `err`=0, state IDLE. The round-robin pointer `last` resets to `NPORTS-1`, so port 0 has top priority after reset.
- **IDLE → XFER:** taken when any `req` bit is high.
  - The winner is the first set bit scanning `last+1, last+2, …` with wrap-around modulo `NPORTS`.
  - On the clock edge: `gnt` ← one-hot winner, `last` ← winner, `beat_cnt` ← the winner's `req_len`.
- **Zero-length request:** if the winner's `req_len` is 0, the block stays in IDLE.
  - `done[winner]` pulses in that IDLE cycle and `last` updates.
  - No `rinc` is issued.
- **XFER:**
  - `rinc = ~rempty`, combinational.
  - Each cycle with `rinc`=1, `beat_cnt` decrements by 1.
  - When `rinc`=1 and `beat_cnt`=1: `done[winner]` is high in the same cycle, and the next edge returns to IDLE with `gnt`←0 and `beat_cnt`←0.
  - When `rempty`=1: `rinc`=0 and the block waits in XFER with no count change.
- **Request changes during XFER:**
  - Deasserting the granted `req` bit mid-packet is ignored; the packet completes.
  - New requests from other ports wait for the next IDLE.
- **Simultaneous requests:** exactly one is granted. Every requesting port is served within `NPORTS` grants.
- **Reset mid-packet:** all outputs return to reset values immediately and asynchronously, and the partial packet is abandoned.

## Timing
- **Grant latency:** a request sampled high in IDLE gives `gnt` and `busy` high on the next edge. The first `rinc` can occur in that same cycle.
- **Packet duration:** a packet of L beats with `rempty`=0 throughout occupies XFER for exactly L cycles.
- **Inter-packet bubble:** one mandatory IDLE cycle separates consecutive packets, so back-to-back throughput is L/(L+1).
- **Output types:** `rinc` and `done` are combinational from registered state and `rempty`. `gnt`, `busy` and `beat_cnt` are registered.

## Configuration
- **`ARB_TIMEOUT_EN` defined:**
  - A stall counter counts consecutive XFER cycles with `rempty`=1, and clears on any `rinc`.
  - When it reaches `TIMEOUT`, `err` pulses for one cycle and the block aborts to IDLE: `gnt`←0, `beat_cnt`←0, no `done`.
- **`ARB_TIMEOUT_EN` undefined:** there is no stall counter, `err` is tied to 0, and XFER waits indefinitely.

## Test plan
- **Reset then single request:** `req`=3'b010 with len 4 and `rempty`=0 → `gnt`=010 on the next edge; `rinc` high for 4 cycles; `done[1]` in the 4th cycle; IDLE follows.
- **Round-robin:** `req`=3'b111 held, all lengths 2 → grant order 0, 1, 2, 0, with one IDLE cycle between packets.
- **Empty stall:** port 2, len 3, `rempty` high for 5 cycles after the first beat → `rinc` low for those 5 cycles, `beat_cnt` holds at 2, packet completes after `rempty` falls.
- **Zero length and drop:**
  - Port 0 with len 0 → `done[0]` pulses in IDLE with no `rinc`, and port 1 is granted next.
  - Port 1 drops `req` mid-packet → its packet still completes.
- **Reset mid-packet:** assert `rst`=0 at beat 2 of 5 → outputs clear immediately; after release, port 0 has priority.
- **`ARB_TIMEOUT_EN`:** `TIMEOUT`=16 with `rempty` held high in XFER → `err` pulses on the 16th stall cycle, then IDLE and `gnt`=0. Without the macro, the same stimulus holds `err` at 0.
